// File: rtl/obuffer_pack_pkg.sv
// Constants shared by the output packer and the input byte serializer.
package obuffer_pack_pkg;

  localparam int DW_C     = 8;
  localparam int NB_C     = 4;
  localparam int WW_C     = DW_C * NB_C;
  localparam int QDEPTH_C = 2;
  localparam int CNTW_C   = $clog2(NB_C);

  typedef logic [WW_C-1:0] word_t;

endpackage

// File: rtl/obuf_fifo.sv
// Small synchronous FIFO; head is visible on rdata whenever empty is low.
module obuf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push_s, do_pop_s;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == LW'(0));
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the slot the write lands in.
  always_comb begin
    do_push_s = push & (~full | pop);
    do_pop_s  = pop & ~empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    level_d = level_q + LW'(do_push_s) - LW'(do_pop_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/obuffer_pack.sv
// Packs the MAC-array byte stream MSB-first into words and queues them toward the result writer.
module obuffer_pack
  import obuffer_pack_pkg::*;
#(
  parameter int DW     = DW_C,
  parameter int NB     = NB_C,
  parameter int QDEPTH = QDEPTH_C
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic [DW-1:0]    IData,
  input  logic             FLUSH,
  input  logic             OReady,
  output logic [DW*NB-1:0] OWord,
  output logic             OValid,
  output logic             Overflow,
  output logic             Busy
);

  localparam int WW = DW * NB;
  localparam int CW = $clog2(NB);
  localparam int LW = $clog2(QDEPTH) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] shift_q, shift_d;
  logic [WW-1:0] hold_q, hold_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;

  logic [WW-1:0] word_s;
  logic          push_req_s, fifo_push_s, pop_s;
  logic [WW-1:0] head_s;
  logic          full_s, empty_s;
  logic [LW-1:0] level_s, level_nxt_s;

  obuf_fifo #(.WIDTH(WW), .DEPTH(QDEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RSTN),
    .push  (fifo_push_s),
    .pop   (pop_s),
    .wdata (word_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level_s)
  );

  // Insert the incoming byte, then decide between completion, flush and plain fill.
  always_comb begin
    word_s     = shift_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    push_req_s = 1'b0;
    if (EN) begin
      for (int i = 0; i < NB; i++) begin
        if (cnt_q == CW'(i)) begin
          word_s[(NB-1-i)*DW +: DW] = IData;
        end else begin
          word_s[(NB-1-i)*DW +: DW] = shift_q[(NB-1-i)*DW +: DW];
        end
      end
    end else begin
      word_s = shift_q;
    end
    if ((EN && (cnt_q == CW'(NB-1))) || (FLUSH && (EN || (cnt_q != CW'(0))))) begin
      push_req_s = 1'b1;
      cnt_d      = CW'(0);
      shift_d    = '0;
    end else if (EN) begin
      cnt_d   = cnt_q + CW'(1);
      shift_d = word_s;
    end else begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
    end
  end

  // Queue handshake: a completed word is dropped only if the queue stays full this cycle.
  always_comb begin
    pop_s       = ~empty_s & OReady;
    fifo_push_s = push_req_s & (~full_s | pop_s);
    ovf_d       = ovf_q | (push_req_s & full_s & ~pop_s);
    level_nxt_s = level_s + LW'(fifo_push_s) - LW'(pop_s);
    busy_d      = (cnt_d != CW'(0)) | (level_nxt_s != LW'(0));
    if (pop_s) begin
      hold_d = head_s;
    end else begin
      hold_d = hold_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  // Between words OWord keeps showing the last word handed downstream.
  assign OValid   = ~empty_s;
  assign OWord    = empty_s ? hold_q : head_s;
  assign Overflow = ovf_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_obuffer_pack.sv
// Directed bench for obuffer_pack with hand-computed expected words.
module tb_obuffer_pack;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        EN = 1'b0;
  logic [7:0]  IData = 8'h00;
  logic        FLUSH = 1'b0;
  logic        OReady = 1'b0;
  logic [31:0] OWord;
  logic        OValid;
  logic        Overflow;
  logic        Busy;

  int n_checks = 0;
  int n_fail   = 0;

  obuffer_pack dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .EN       (EN),
    .IData    (IData),
    .FLUSH    (FLUSH),
    .OReady   (OReady),
    .OWord    (OWord),
    .OValid   (OValid),
    .Overflow (Overflow),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    EN    = 1'b1;
    IData = b;
    tick();
    EN    = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("rst_ovalid", {31'd0, OValid}, 32'd0);
    check_eq("rst_oword", OWord, 32'd0);
    check_eq("rst_ovf", {31'd0, Overflow}, 32'd0);
    check_eq("rst_busy", {31'd0, Busy}, 32'd0);
    RSTN   = 1'b1;
    OReady = 1'b1;
    tick();

    // Back-to-back word, one-cycle latency, single-cycle pulse
    send_byte(8'hDE);
    check_eq("t1_b1_ovalid", {31'd0, OValid}, 32'd0);
    check_eq("t1_b1_busy", {31'd0, Busy}, 32'd1);
    send_byte(8'hAD);
    send_byte(8'hBE);
    check_eq("t1_b3_ovalid", {31'd0, OValid}, 32'd0);
    send_byte(8'hEF);
    check_eq("t1_ovalid", {31'd0, OValid}, 32'd1);
    check_eq("t1_oword", OWord, 32'hDEADBEEF);
    tick();
    check_eq("t1_pulse", {31'd0, OValid}, 32'd0);
    check_eq("t1_hold", OWord, 32'hDEADBEEF);
    check_eq("t1_busy", {31'd0, Busy}, 32'd0);

    // Idle gaps between bytes
    send_byte(8'h11);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t2_gap_ovalid", {31'd0, OValid}, 32'd0);
      check_eq("t2_gap_busy", {31'd0, Busy}, 32'd1);
    end
    send_byte(8'h22);
    send_byte(8'h33);
    check_eq("t2_b3_ovalid", {31'd0, OValid}, 32'd0);
    send_byte(8'h44);
    check_eq("t2_oword", OWord, 32'h11223344);
    check_eq("t2_ovalid", {31'd0, OValid}, 32'd1);
    tick();

    // Flush of a partial word
    send_byte(8'hAA);
    send_byte(8'hBB);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check_eq("t3_flush_ovalid", {31'd0, OValid}, 32'd1);
    check_eq("t3_flush_word", OWord, 32'hAABB0000);
    tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check_eq("t3_empty_flush", {31'd0, OValid}, 32'd0);
    check_eq("t3_empty_busy", {31'd0, Busy}, 32'd0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    FLUSH = 1'b1;
    send_byte(8'hCC);
    FLUSH = 1'b0;
    check_eq("t3_en_flush", OWord, 32'hAABBCC00);
    check_eq("t3_en_flush_v", {31'd0, OValid}, 32'd1);
    tick();
    // Flush on the completing byte adds no extra word
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    FLUSH = 1'b1;
    send_byte(8'h04);
    FLUSH = 1'b0;
    check_eq("t3_full_flush", OWord, 32'h01020304);
    tick();
    check_eq("t3_no_extra", {31'd0, OValid}, 32'd0);
    check_eq("t3_no_extra_busy", {31'd0, Busy}, 32'd0);

    // Overflow with OReady low
    OReady = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int b = 1; b <= 4; b++) send_byte(8'(w * 4 + b));
    end
    check_eq("t4_ovf", {31'd0, Overflow}, 32'd1);
    check_eq("t4_head", OWord, 32'h01020304);
    check_eq("t4_busy", {31'd0, Busy}, 32'd1);
    OReady = 1'b1;
    tick();
    check_eq("t4_second", OWord, 32'h05060708);
    check_eq("t4_second_v", {31'd0, OValid}, 32'd1);
    tick();
    check_eq("t4_drained", {31'd0, OValid}, 32'd0);
    check_eq("t4_drain_hold", OWord, 32'h05060708);
    check_eq("t4_ovf_sticky", {31'd0, Overflow}, 32'd1);

    // Async reset with a word queued and a partial word held
    OReady = 1'b0;
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hA4);
    send_byte(8'hB1);
    send_byte(8'hB2);
    check_eq("t6_pre_valid", {31'd0, OValid}, 32'd1);
    RSTN = 1'b0;
    #2;
    check_eq("t6_rst_ovalid", {31'd0, OValid}, 32'd0);
    check_eq("t6_rst_busy", {31'd0, Busy}, 32'd0);
    check_eq("t6_rst_ovf", {31'd0, Overflow}, 32'd0);
    check_eq("t6_rst_oword", OWord, 32'd0);
    RSTN   = 1'b1;
    OReady = 1'b1;
    tick();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    check_eq("t6_after_rst", OWord, 32'h01020304);
    check_eq("t6_after_rst_v", {31'd0, OValid}, 32'd1);
    tick();

    // Full queue, push and pop on the same edge
    OReady = 1'b0;
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    send_byte(8'h50); send_byte(8'h60); send_byte(8'h70); send_byte(8'h80);
    send_byte(8'h90); send_byte(8'hA0); send_byte(8'hB0);
    check_eq("t5_head", OWord, 32'h10203040);
    OReady = 1'b1;
    send_byte(8'hC0);
    check_eq("t5_no_ovf", {31'd0, Overflow}, 32'd0);
    check_eq("t5_order1", OWord, 32'h50607080);
    tick();
    check_eq("t5_order2", OWord, 32'h90A0B0C0);
    check_eq("t5_order2_v", {31'd0, OValid}, 32'd1);
    tick();
    check_eq("t5_empty", {31'd0, OValid}, 32'd0);
    check_eq("t5_busy", {31'd0, Busy}, 32'd0);
    check_eq("t5_ovf_end", {31'd0, Overflow}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obuffer_pack.md
Name: obuffer_pack

Overview:
Output-side packer for the MAC array edge. It is the inverse of the input byte serializer: it collects the byte stream leaving the array, tagged by an enable strobe, MSB-first into 32-bit words. Completed words go to a small output queue with a valid/ready handshake toward the result writer/FSM. Partial words can be force-flushed at the end of a tile.

Parameters:
DW, 8, data byte width
NB, 4, bytes per packed word (word width = DW*NB = 32)
QDEPTH, 2, output word queue depth (power of 2, >=2)

Ports:
CLK  input  1  clock, all state updates on rising edge
RSTN  input  1  asynchronous active-low reset
EN  input  1  IData valid this cycle (the strobe travelling alongside the data)
IData  input  8  incoming byte
FLUSH  input  1  single-cycle request: emit partial word zero-padded
OReady  input  1  downstream accepts OWord this cycle
OWord  output  32  head-of-queue word
OValid  output  1  OWord valid
Overflow  output  1  sticky: a completed word was dropped (queue full)
Busy  output  1  partial word held (count != 0) or queue non-empty

Behaviour:
- Reset (async, RSTN=0): count=0, shift reg=0, queue empty, OWord=0, OValid=0, Overflow=0, Busy=0. Reset mid-word discards the partial word and all queued words.
- Packing order: the first byte after an empty shift reg lands in OWord[31:24], the second in [23:16], then [15:8] and [7:0]. This mirrors the serializer, which emits [31:24] first.
- Counter: count 0..NB-1. On each EN=1 cycle, the byte is written at slot `count` and count increments. When count would reach NB, the word completes and count wraps to 0.
- States (implicit in count): IDLE (count=0), FILL (count 1..3). No other state.
- Completion: the word is pushed into the queue on the same edge that samples the 4th byte. OValid rises on the following cycle, giving a latency of 1 cycle from the last EN.
- FLUSH:
  - With count>0: the word is pushed with unfilled slots = 0, and count resets to 0.
  - With count=0 and EN=0: no-op.
  - With EN=1 in the same cycle: the byte is included first. If that byte completes the word, FLUSH adds nothing extra.
- Queue: FIFO of QDEPTH entries. The head drives OWord/OValid.
  - Pop on OValid & OReady.
  - Push and pop in the same cycle when full: legal, no overflow, occupancy unchanged.
  - Push when full without pop: the word is dropped and Overflow is set.
  - Overflow clears only on reset.
- OWord holds its value while OValid=0 (last popped value or 0 after reset). It is stable while OValid=1 and OReady=0.
- EN gaps: any number of idle cycles between bytes is legal, and the partial word is held indefinitely.
- Busy is registered: (count!=0) | (queue non-empty).

Decomposition:
- Shared package: DW, NB, word width constant, QDEPTH default, and the count width constant $clog2(NB). These constants are shared with the input serializer.
- One natural sub-module: obuf_fifo (a parameterized synchronous FIFO with push/pop/full/empty, no overflow logic inside). The packer owns the drop/Overflow decision.

Test Plan:
- Bytes 0xDE,0xAD,0xBE,0xEF on 4 consecutive EN cycles, OReady=1 -> OValid=1 exactly 1 cycle after the 4th byte, OWord=0xDEADBEEF, single-cycle pulse.
- Bytes 0x11,0x22 with 5 idle cycles between them, then 0x33,0x44 -> OWord=0x11223344, with no OValid before the 4th byte.
- Bytes 0xAA,0xBB then FLUSH -> OWord=0xAABB0000. FLUSH alone with count=0 -> no OValid. EN=1 (0xCC) with FLUSH at count=2 -> OWord=0xAABBCC00.
- OReady=0, three full words 0x01020304, 0x05060708, 0x090A0B0C -> queue holds the first two, Overflow=1 after the 3rd completes. Then OReady=1 -> 0x01020304 and 0x05060708 pop in order, Overflow stays 1.
- Queue full with OReady=1 on the cycle a new word completes -> no Overflow, the words keep their order.
- RSTN pulse low after 2 bytes and with 1 word queued -> OValid=0, Busy=0 immediately (async). Next 4 bytes 0x01..0x04 -> OWord=0x01020304.
